// File: rtl/button_conditioner_pkg.sv
// Shared constants for the front-panel input conditioner: channel indices,
// the default debounce window and the counter width helper.
package button_conditioner_pkg;

    localparam int CH_RESET  = 0;
    localparam int CH_RECORD = 1;
    localparam int CH_PLAY   = 2;
    localparam int CH_CLIP_R = 3;
    localparam int CH_CLIP_P = 4;

    localparam int NUM_FRONT_PANEL_CH  = 5;
    localparam int DEBOUNCE_1MS_100MHZ = 100000;

    // Width that holds 0..cycles, so DEBOUNCE_CYCLES-1 always fits.
    function automatic int cnt_width(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/button_channel.sv
// One conditioned input: synchroniser chain, debounce counter, committed level,
// registered rise/fall strobes and an optional toggle latch.
module button_channel
    import button_conditioner_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_1MS_100MHZ,
    parameter bit TOGGLE_EN       = 1'b0
) (
    input  logic clock_i,
    input  logic Reset_async,
    input  logic btn_async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic toggle_o
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_level;
    logic                   r_rise;
    logic                   r_fall;
    logic                   r_toggle;

    logic w_sync;
    logic w_mismatch;
    logic w_commit;

    assign w_sync     = r_sync[SYNC_STAGES-1];
    assign w_mismatch = (w_sync != r_level);
    assign w_commit   = w_mismatch && (r_cnt == CNT_LAST);

    always_ff @(posedge clock_i or posedge Reset_async) begin
        if (Reset_async) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], btn_async_i};
        end
    end

    // Any cycle of agreement restarts the window, so bounces never commit.
    always_ff @(posedge clock_i or posedge Reset_async) begin
        if (Reset_async) begin
            r_cnt <= '0;
        end else if (!w_mismatch || w_commit) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock_i or posedge Reset_async) begin
        if (Reset_async) begin
            r_level  <= 1'b0;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
            r_toggle <= 1'b0;
        end else begin
            r_rise <= w_commit &  w_sync;
            r_fall <= w_commit & ~w_sync;
            if (w_commit) begin
                r_level <= w_sync;
            end
            if (TOGGLE_EN && w_commit && w_sync) begin
                r_toggle <= ~r_toggle;
            end
        end
    end

    assign level_o  = r_level;
    assign rise_o   = r_rise;
    assign fall_o   = r_fall;
    assign toggle_o = r_toggle;

endmodule

// File: rtl/button_conditioner.sv
// Front-panel input conditioner: NUM_CH independent debounced channels feeding
// the recorder control FSM; every output comes straight from a flop.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int                NUM_CH          = NUM_FRONT_PANEL_CH,
    parameter int                SYNC_STAGES     = 2,
    parameter int                DEBOUNCE_CYCLES = DEBOUNCE_1MS_100MHZ,
    parameter logic [NUM_CH-1:0] TOGGLE_MASK     = '0
) (
    input  logic              clock_i,
    input  logic              Reset_async,
    input  logic [NUM_CH-1:0] btn_async_i,
    output logic [NUM_CH-1:0] level_o,
    output logic [NUM_CH-1:0] rise_o,
    output logic [NUM_CH-1:0] fall_o,
    output logic [NUM_CH-1:0] toggle_o
);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            button_channel #(
                .SYNC_STAGES     (SYNC_STAGES),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .TOGGLE_EN       (TOGGLE_MASK[gi])
            ) u_channel (
                .clock_i     (clock_i),
                .Reset_async (Reset_async),
                .btn_async_i (btn_async_i[gi]),
                .level_o     (level_o[gi]),
                .rise_o      (rise_o[gi]),
                .fall_o      (fall_o[gi]),
                .toggle_o    (toggle_o[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with a 4-cycle debounce window and
// toggle enabled on channel 3 only.
module tb_button_conditioner;
    import button_conditioner_pkg::*;

    localparam int         NCH = 5;
    localparam int         SS  = 2;
    localparam int         DB  = 4;
    localparam logic [4:0] TM  = 5'b01000;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [NCH-1:0] btn = '0;
    logic [NCH-1:0] level;
    logic [NCH-1:0] rise;
    logic [NCH-1:0] fall;
    logic [NCH-1:0] toggle;

    int tests_run    = 0;
    int tests_failed = 0;

    button_conditioner #(
        .NUM_CH          (NCH),
        .SYNC_STAGES     (SS),
        .DEBOUNCE_CYCLES (DB),
        .TOGGLE_MASK     (TM)
    ) dut (
        .clock_i     (clk),
        .Reset_async (rst),
        .btn_async_i (btn),
        .level_o     (level),
        .rise_o      (rise),
        .fall_o      (fall),
        .toggle_o    (toggle)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        btn = '0;
        settle(3);
        tests_run++;
        if ({level, rise, fall, toggle} !== 20'h0) begin
            tests_failed++;
            $display("FAIL reset_held: got %h want 00000", {level, rise, fall, toggle});
        end
        rst = 1'b0;
        tick();
        tests_run++;
        if ({level, rise, fall, toggle} !== 20'h0) begin
            tests_failed++;
            $display("FAIL reset_release: got %h want 00000", {level, rise, fall, toggle});
        end
        $display("[TB] test_reset done");
    endtask

    task automatic test_clean_step();
        logic [4:0] lvl5, lvl6, rise6, rise7;
        int other, fall_edge;
        other = 0;
        fall_edge = -1;
        lvl5 = 'x; lvl6 = 'x; rise6 = 'x; rise7 = 'x;
        btn[CH_PLAY] = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            if (e == 5) lvl5 = level;
            if (e == 6) begin lvl6 = level; rise6 = rise; end
            if (e == 7) rise7 = rise;
            if (((rise | fall) & 5'b11011) != 0) other++;
        end
        tests_run++;
        if (lvl5 !== 5'b00000) begin tests_failed++; $display("FAIL step_level_e5: got %b want 00000", lvl5); end
        tests_run++;
        if (lvl6 !== 5'b00100) begin tests_failed++; $display("FAIL step_level_e6: got %b want 00100", lvl6); end
        tests_run++;
        if (rise6 !== 5'b00100) begin tests_failed++; $display("FAIL step_rise_e6: got %b want 00100", rise6); end
        tests_run++;
        if (rise7 !== 5'b00000) begin tests_failed++; $display("FAIL step_rise_e7: got %b want 00000", rise7); end
        tests_run++;
        if (other != 0) begin tests_failed++; $display("FAIL step_other_quiet: got %0d strobes want 0", other); end
        btn[CH_PLAY] = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            tick();
            if (fall[CH_PLAY] && fall_edge < 0) fall_edge = e;
        end
        tests_run++;
        if (fall_edge != 6) begin tests_failed++; $display("FAIL step_fall_edge: got %0d want 6", fall_edge); end
        $display("[TB] test_clean_step done");
    endtask

    task automatic test_bounce();
        int rises, falls, rise_edge;
        logic lvl9, lvl_end;
        rises = 0; falls = 0; rise_edge = -1;
        lvl9 = 1'bx;
        for (int e = 1; e <= 16; e++) begin
            btn[CH_RECORD] = ((e - 1) != 3);
            tick();
            if (rise[CH_RECORD]) begin rises++; if (rise_edge < 0) rise_edge = e; end
            if (fall[CH_RECORD]) falls++;
            if (e == 9) lvl9 = level[CH_RECORD];
        end
        lvl_end = level[CH_RECORD];
        tests_run++;
        if (rises != 1) begin tests_failed++; $display("FAIL bounce_rise_count: got %0d want 1", rises); end
        tests_run++;
        if (rise_edge != 10) begin tests_failed++; $display("FAIL bounce_rise_edge: got %0d want 10", rise_edge); end
        tests_run++;
        if (falls != 0) begin tests_failed++; $display("FAIL bounce_no_fall: got %0d want 0", falls); end
        tests_run++;
        if (lvl9 !== 1'b0) begin tests_failed++; $display("FAIL bounce_level_e9: got %b want 0", lvl9); end
        tests_run++;
        if (lvl_end !== 1'b1) begin tests_failed++; $display("FAIL bounce_level_end: got %b want 1", lvl_end); end
        btn[CH_RECORD] = 1'b0;
        settle(10);
        $display("[TB] test_bounce done");
    endtask

    task automatic test_toggle();
        logic t5, t6, t21, t22, r6;
        int tog2_bad, rises;
        tog2_bad = 0; rises = 0;
        t5 = 1'bx; t6 = 1'bx; t21 = 1'bx; t22 = 1'bx; r6 = 1'bx;
        for (int e = 1; e <= 32; e++) begin
            btn[CH_CLIP_R] = (((e - 1) % 16) < 8);
            tick();
            if (rise[CH_CLIP_R]) rises++;
            if (toggle[CH_PLAY] !== 1'b0) tog2_bad++;
            if (e == 5)  t5  = toggle[CH_CLIP_R];
            if (e == 6)  begin t6 = toggle[CH_CLIP_R]; r6 = rise[CH_CLIP_R]; end
            if (e == 21) t21 = toggle[CH_CLIP_R];
            if (e == 22) t22 = toggle[CH_CLIP_R];
        end
        tests_run++;
        if (t5 !== 1'b0) begin tests_failed++; $display("FAIL toggle_e5: got %b want 0", t5); end
        tests_run++;
        if (t6 !== 1'b1) begin tests_failed++; $display("FAIL toggle_e6: got %b want 1", t6); end
        tests_run++;
        if (r6 !== 1'b1) begin tests_failed++; $display("FAIL toggle_rise_e6: got %b want 1", r6); end
        tests_run++;
        if (t21 !== 1'b1) begin tests_failed++; $display("FAIL toggle_e21: got %b want 1", t21); end
        tests_run++;
        if (t22 !== 1'b0) begin tests_failed++; $display("FAIL toggle_e22: got %b want 0", t22); end
        tests_run++;
        if (rises != 2) begin tests_failed++; $display("FAIL toggle_rise_count: got %0d want 2", rises); end
        tests_run++;
        if (tog2_bad != 0) begin tests_failed++; $display("FAIL toggle_ch2_quiet: got %0d cycles want 0", tog2_bad); end
        settle(4);
        $display("[TB] test_toggle done");
    endtask

    task automatic test_all_channels();
        logic [4:0] rise5, rise6, fall16;
        rise5 = 'x; rise6 = 'x; fall16 = 'x;
        for (int e = 1; e <= 20; e++) begin
            btn = ((e - 1) < 10) ? 5'b11111 : 5'b00000;
            tick();
            if (e == 5)  rise5  = rise;
            if (e == 6)  rise6  = rise;
            if (e == 16) fall16 = fall;
        end
        tests_run++;
        if (rise5 !== 5'b00000) begin tests_failed++; $display("FAIL all_rise_e5: got %b want 00000", rise5); end
        tests_run++;
        if (rise6 !== 5'b11111) begin tests_failed++; $display("FAIL all_rise_e6: got %b want 11111", rise6); end
        tests_run++;
        if (fall16 !== 5'b11111) begin tests_failed++; $display("FAIL all_fall_e16: got %b want 11111", fall16); end
        settle(6);
        $display("[TB] test_all_channels done");
    endtask

    task automatic test_reset_midcount();
        logic [4:0] rise5, rise6, rise7;
        rise5 = 'x; rise6 = 'x; rise7 = 'x;
        btn[CH_RESET] = 1'b1;
        settle(4);
        rst = 1'b1;
        #1;
        tests_run++;
        if ({level, rise, fall, toggle} !== 20'h0) begin
            tests_failed++;
            $display("FAIL midreset_async: got %h want 00000", {level, rise, fall, toggle});
        end
        settle(2);
        tests_run++;
        if ({level, rise, fall, toggle} !== 20'h0) begin
            tests_failed++;
            $display("FAIL midreset_held: got %h want 00000", {level, rise, fall, toggle});
        end
        rst = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            if (e == 5) rise5 = rise;
            if (e == 6) rise6 = rise;
            if (e == 7) rise7 = rise;
        end
        tests_run++;
        if (rise5 !== 5'b00000) begin tests_failed++; $display("FAIL midreset_rise_e5: got %b want 00000", rise5); end
        tests_run++;
        if (rise6 !== 5'b00001) begin tests_failed++; $display("FAIL midreset_rise_e6: got %b want 00001", rise6); end
        tests_run++;
        if (rise7 !== 5'b00000) begin tests_failed++; $display("FAIL midreset_rise_e7: got %b want 00000", rise7); end
        btn[CH_RESET] = 1'b0;
        settle(10);
        $display("[TB] test_reset_midcount done");
    endtask

    task automatic test_glitch();
        int lvl_bad, rise_bad, fall_bad;
        lvl_bad = 0; rise_bad = 0; fall_bad = 0;
        for (int g = 0; g < 10; g++) begin
            tick();
            #2 btn[CH_CLIP_P] = 1'b1;
            #3 btn[CH_CLIP_P] = 1'b0;
            if (level[CH_CLIP_P]) lvl_bad++;
            if (rise[CH_CLIP_P])  rise_bad++;
            if (fall[CH_CLIP_P])  fall_bad++;
        end
        btn[CH_CLIP_P] = 1'b1;
        tick();
        btn[CH_CLIP_P] = 1'b0;
        for (int e = 0; e < 12; e++) begin
            tick();
            if (level[CH_CLIP_P]) lvl_bad++;
            if (rise[CH_CLIP_P])  rise_bad++;
            if (fall[CH_CLIP_P])  fall_bad++;
        end
        tests_run++;
        if (lvl_bad != 0) begin tests_failed++; $display("FAIL glitch_level: got %0d cycles high want 0", lvl_bad); end
        tests_run++;
        if (rise_bad != 0) begin tests_failed++; $display("FAIL glitch_rise: got %0d pulses want 0", rise_bad); end
        tests_run++;
        if (fall_bad != 0) begin tests_failed++; $display("FAIL glitch_fall: got %0d pulses want 0", fall_bad); end
        $display("[TB] test_glitch done");
    endtask

    initial begin
        test_reset();
        test_clean_step();
        test_bounce();
        test_toggle();
        test_all_channels();
        test_reset_midcount();
        test_glitch();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
